// File: rtl/alu_pkg.sv
// Shared ALU constants and types for the two-requester ALU arbiter.
package alu_pkg;
  localparam int DATA_W = 32;

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_ILL  = 3'b011;
  localparam logic [2:0] OP_ANDN = 3'b100;
  localparam logic [2:0] OP_ORN  = 3'b101;
  localparam logic [2:0] OP_SUB  = 3'b110;
  localparam logic [2:0] OP_SLT  = 3'b111;

  typedef enum logic {ST_EMPTY, ST_FULL} arb_state_e;

  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [2:0]        sel;
  } alu_req_t;

  typedef struct packed {
    logic              id;
    logic [DATA_W-1:0] data;
    logic              zero;
    logic              err;
  } alu_rsp_t;
endpackage

// File: rtl/alu_arbiter_if.sv
// Requester and response handshake bundle for alu_arbiter.
interface alu_arbiter_if;
  import alu_pkg::*;

  logic              r0_valid, r0_ready;
  logic [DATA_W-1:0] r0_a, r0_b;
  logic [2:0]        r0_sel;
  logic              r1_valid, r1_ready;
  logic [DATA_W-1:0] r1_a, r1_b;
  logic [2:0]        r1_sel;
  logic              rsp_valid, rsp_ready, rsp_id, rsp_zero, rsp_err;
  logic [DATA_W-1:0] rsp_data;

  modport master (
    output r0_valid, r0_a, r0_b, r0_sel, r1_valid, r1_a, r1_b, r1_sel, rsp_ready,
    input  r0_ready, r1_ready, rsp_valid, rsp_id, rsp_data, rsp_zero, rsp_err
  );
  modport slave (
    input  r0_valid, r0_a, r0_b, r0_sel, r1_valid, r1_a, r1_b, r1_sel, rsp_ready,
    output r0_ready, r1_ready, rsp_valid, rsp_id, rsp_data, rsp_zero, rsp_err
  );
endinterface

// File: rtl/alu_core.sv
// Combinational ALU: logic ops, wrapping add/sub, signed set-less-than.
module alu_core
  import alu_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [2:0]        sel,
  output logic [DATA_W-1:0] result,
  output logic              zero,
  output logic              err
);
  always_comb begin
    result = '0;
    err    = 1'b0;
    case (sel)
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_ADD:  result = a + b;
      OP_ANDN: result = a & ~b;
      OP_ORN:  result = a | ~b;
      OP_SUB:  result = a - b;
      OP_SLT:  result = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
      default: err    = 1'b1;  // OP_ILL: defined zero result, flagged
    endcase
  end

  assign zero = (result == '0);
endmodule

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for one shared ALU with a one-deep
// response register. Define ALU_ARB_STATS_EN to add saturating grant counters.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  alu_arbiter_if.slave bus
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [CNT_W-1:0] gnt_cnt0,
  output logic [CNT_W-1:0] gnt_cnt1
`endif
);
  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("alu_arbiter: CNT_W must be at least 1");
  end

  arb_state_e state_q, state_d;
  logic       ptr_q, ptr_d;
  alu_rsp_t   rsp_q, rsp_d;

  logic              can_gnt, gnt0, gnt1;
  alu_req_t          req;
  logic [DATA_W-1:0] alu_res;
  logic              alu_zero, alu_err;

  // Same-cycle drain and refill when the consumer is taking the held result.
  assign can_gnt = rst_n && ((state_q == ST_EMPTY) || bus.rsp_ready);
  assign gnt0    = can_gnt && bus.r0_valid && (!bus.r1_valid || ptr_q);
  assign gnt1    = can_gnt && bus.r1_valid && (!bus.r0_valid || !ptr_q);

  assign bus.r0_ready = gnt0;
  assign bus.r1_ready = gnt1;

  assign req = gnt1 ? '{a: bus.r1_a, b: bus.r1_b, sel: bus.r1_sel}
                    : '{a: bus.r0_a, b: bus.r0_b, sel: bus.r0_sel};

  alu_core u_alu (
    .a      (req.a),
    .b      (req.b),
    .sel    (req.sel),
    .result (alu_res),
    .zero   (alu_zero),
    .err    (alu_err)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    rsp_d   = rsp_q;
    if (gnt0 || gnt1) begin
      state_d = ST_FULL;
      ptr_d   = gnt1;
      rsp_d   = '{id: gnt1, data: alu_res, zero: alu_zero, err: alu_err};
    end else if (state_q == ST_FULL && bus.rsp_ready) begin
      state_d = ST_EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      ptr_q   <= 1'b1;
      rsp_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      rsp_q   <= rsp_d;
    end
  end

  assign bus.rsp_valid = (state_q == ST_FULL);
  assign bus.rsp_id    = rsp_q.id;
  assign bus.rsp_data  = rsp_q.data;
  assign bus.rsp_zero  = rsp_q.zero;
  assign bus.rsp_err   = rsp_q.err;

`ifdef ALU_ARB_STATS_EN
  logic [CNT_W-1:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;

  always_comb begin
    cnt0_d = (gnt0 && cnt0_q != '1) ? cnt0_q + 1'b1 : cnt0_q;
    cnt1_d = (gnt1 && cnt1_q != '1) ? cnt1_q + 1'b1 : cnt1_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end

  assign gnt_cnt0 = cnt0_q;
  assign gnt_cnt1 = cnt1_q;
`endif
endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed vectors with literal expectations plus a
// behavioural model compared every cycle. Honours ALU_ARB_STATS_EN.
module tb_alu_arbiter;
  import alu_pkg::*;

  localparam int CNT_W = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  alu_arbiter_if bus();
`ifdef ALU_ARB_STATS_EN
  logic [CNT_W-1:0] gnt_cnt0, gnt_cnt1;
`endif

  alu_arbiter #(.CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef ALU_ARB_STATS_EN
    ,
    .gnt_cnt0 (gnt_cnt0),
    .gnt_cnt1 (gnt_cnt1)
`endif
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic        m_full, m_ptr, m_id, m_zero, m_err;
  logic [31:0] m_data;
  int          m_c0, m_c1;
  localparam int CMAX = (1 << CNT_W) - 1;

  function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                          input logic [2:0] op, output logic bad);
    bad = 1'b0;
    case (op)
      3'd0: return a & b;
      3'd1: return a | b;
      3'd2: return a + b;
      3'd4: return a & ~b;
      3'd5: return a | ~b;
      3'd6: return a - b;
      3'd7: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: begin bad = 1'b1; return 32'd0; end
    endcase
  endfunction

  // Winner from the rules: nothing if blocked; both valid -> the one not last granted.
  function automatic void ref_grant(output logic g0, output logic g1);
    g0 = 1'b0;
    g1 = 1'b0;
    if (m_full && !bus.rsp_ready) return;
    if (bus.r0_valid && bus.r1_valid) begin
      if (m_ptr) g0 = 1'b1; else g1 = 1'b1;
    end else begin
      g0 = bus.r0_valid;
      g1 = bus.r1_valid;
    end
  endfunction

  always @(posedge clk or negedge rst_n) begin
    logic g0, g1, bad;
    logic [31:0] r;
    if (!rst_n) begin
      m_full = 0; m_ptr = 1; m_id = 0; m_data = 0; m_zero = 0; m_err = 0;
      m_c0 = 0; m_c1 = 0;
    end else begin
      ref_grant(g0, g1);
      if (g0 || g1) begin
        if (g1) r = ref_alu(bus.r1_a, bus.r1_b, bus.r1_sel, bad);
        else    r = ref_alu(bus.r0_a, bus.r0_b, bus.r0_sel, bad);
        m_full = 1; m_id = g1; m_data = r; m_zero = (r == 0); m_err = bad; m_ptr = g1;
        if (g0 && m_c0 < CMAX) m_c0++;
        if (g1 && m_c1 < CMAX) m_c1++;
      end else if (m_full && bus.rsp_ready) begin
        m_full = 0;
      end
    end
  end

  always @(negedge clk) begin
    logic g0, g1;
    if (rst_n) begin
      ref_grant(g0, g1);
      chk("m_r0_ready", bus.r0_ready, g0);
      chk("m_r1_ready", bus.r1_ready, g1);
      chk("m_rsp_valid", bus.rsp_valid, m_full);
      if (m_full) begin
        chk("m_rsp_id", bus.rsp_id, m_id);
        chk("m_rsp_data", bus.rsp_data, m_data);
        chk("m_rsp_zero", bus.rsp_zero, m_zero);
        chk("m_rsp_err", bus.rsp_err, m_err);
      end
`ifdef ALU_ARB_STATS_EN
      chk("m_gnt_cnt0", gnt_cnt0, m_c0);
      chk("m_gnt_cnt1", gnt_cnt1, m_c1);
`endif
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_r0(input logic v, input logic [31:0] a, input logic [31:0] b, input logic [2:0] s);
    bus.r0_valid = v; bus.r0_a = a; bus.r0_b = b; bus.r0_sel = s;
  endtask

  task automatic set_r1(input logic v, input logic [31:0] a, input logic [31:0] b, input logic [2:0] s);
    bus.r1_valid = v; bus.r1_a = a; bus.r1_b = b; bus.r1_sel = s;
  endtask

  task automatic apply_reset();
    set_r0(0, 0, 0, 0);
    set_r1(0, 0, 0, 0);
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    set_r0(1, 32'h11, 32'h22, OP_ADD);
    set_r1(0, 0, 0, 0);
    bus.rsp_ready = 1'b0;

    // Reset values, with a requester valid to show ready stays low.
    #2 rst_n = 1'b0;
    #1;
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_rsp_id", bus.rsp_id, 0);
    chk("rst_rsp_data", bus.rsp_data, 0);
    chk("rst_rsp_zero", bus.rsp_zero, 0);
    chk("rst_rsp_err", bus.rsp_err, 0);
    chk("rst_r0_ready", bus.r0_ready, 0);
    apply_reset();

    // Single add, one-cycle latency.
    bus.rsp_ready = 1'b1;
    set_r0(1, 5, 7, OP_ADD);
    @(negedge clk);
    chk("add_r0_ready", bus.r0_ready, 1);
    step();
    set_r0(0, 0, 0, 0);
    @(negedge clk);
    chk("add_rsp_valid", bus.rsp_valid, 1);
    chk("add_rsp_id", bus.rsp_id, 0);
    chk("add_rsp_data", bus.rsp_data, 12);
    chk("add_rsp_zero", bus.rsp_zero, 0);
    step();

    // Both valid every cycle: grants alternate starting at requester 0.
    apply_reset();
    bus.rsp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      set_r0(1, k, 10, OP_ADD);
      set_r1(1, 100, k, OP_SUB);
      @(negedge clk);
      chk("alt_r0_ready", bus.r0_ready, (k % 2) == 0);
      chk("alt_r1_ready", bus.r1_ready, (k % 2) == 1);
      if (k > 0) chk("alt_rsp_id", bus.rsp_id, (k - 1) % 2);
      step();
    end
    set_r0(0, 0, 0, 0);
    set_r1(0, 0, 0, 0);
    @(negedge clk);
    chk("alt_rsp_id_last", bus.rsp_id, 1);
    step();

    // Back-pressure: SLT(-1,0)=1 held while inputs change.
    apply_reset();
    bus.rsp_ready = 1'b0;
    set_r1(1, 32'hFFFF_FFFF, 0, OP_SLT);
    @(negedge clk);
    chk("bp_r1_ready", bus.r1_ready, 1);
    step();
    set_r1(1, 5, 32'hFFFF_FFFD, OP_SLT);
    set_r0(1, 9, 9, OP_SUB);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_rsp_data", bus.rsp_data, 1);
      chk("bp_rsp_id", bus.rsp_id, 1);
      chk("bp_r0_ready", bus.r0_ready, 0);
      chk("bp_r1_ready", bus.r1_ready, 0);
      step();
    end
    set_r0(0, 0, 0, 0);
    set_r1(0, 0, 0, 0);
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_still_valid", bus.rsp_valid, 1);
    step();
    @(negedge clk);
    chk("bp_drained", bus.rsp_valid, 0);
    step();

    // Illegal op code and signed-overflow wrap.
    set_r0(1, 32'h1234, 32'h55, OP_ILL);
    step();
    set_r0(1, 32'h7FFF_FFFF, 1, OP_ADD);
    @(negedge clk);
    chk("ill_rsp_data", bus.rsp_data, 0);
    chk("ill_rsp_zero", bus.rsp_zero, 1);
    chk("ill_rsp_err", bus.rsp_err, 1);
    step();
    set_r0(0, 0, 0, 0);
    @(negedge clk);
    chk("ovf_rsp_data", bus.rsp_data, 32'h8000_0000);
    chk("ovf_rsp_err", bus.rsp_err, 0);
    step();

    // Every op code through both requesters, model-checked.
    for (int op = 0; op < 8; op++) begin
      set_r0(1, 32'hF0F0_1234, 32'h0FF0_8001, op[2:0]);
      set_r1(1, 32'hFFFF_FFFB, 32'd3, op[2:0]);
      step();
      step();
    end
    set_r0(0, 0, 0, 0);
    set_r1(0, 0, 0, 0);
    step();

    // Mixed traffic with random valids and back-pressure.
    for (int k = 0; k < 80; k++) begin
      set_r0($urandom_range(0, 1), $urandom, (k % 5 == 0) ? 32'd0 : $urandom, 3'($urandom_range(0, 7)));
      set_r1($urandom_range(0, 1), $urandom, $urandom, 3'($urandom_range(0, 7)));
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    set_r0(0, 0, 0, 0);
    set_r1(0, 0, 0, 0);
    bus.rsp_ready = 1'b1;
    step();

    // Asynchronous reset while FULL, then fresh arbitration.
    bus.rsp_ready = 1'b0;
    set_r1(1, 3, 4, OP_OR);
    step();
    set_r1(0, 0, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_rsp_valid", bus.rsp_valid, 0);
    chk("arst_rsp_data", bus.rsp_data, 0);
    step();
    rst_n = 1'b1;
    bus.rsp_ready = 1'b1;
    set_r0(1, 1, 1, OP_AND);
    set_r1(1, 2, 2, OP_AND);
    @(negedge clk);
    chk("arst_first_r0", bus.r0_ready, 1);
    chk("arst_first_r1", bus.r1_ready, 0);
    step();
    set_r0(0, 0, 0, 0);
    set_r1(0, 0, 0, 0);
    step();

`ifdef ALU_ARB_STATS_EN
    apply_reset();
    bus.rsp_ready = 1'b1;
    set_r0(1, 1, 2, OP_ADD);
    repeat (5) step();
    set_r0(0, 0, 0, 0);
    @(negedge clk);
    chk("sat_gnt_cnt0", gnt_cnt0, 3);
    chk("sat_gnt_cnt1", gnt_cnt1, 0);
    step();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: CNT_W, 16, width of grant statistics counters (used only with ALU_ARB_STATS_EN).
REQ-002 clk  input  1  single clock, all state on rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 rN_valid  input  1  requester N (N=0,1) presents an operation.
REQ-005 rN_ready  output  1  requester N operation accepted this cycle.
REQ-006 rN_a  input  32  requester N signed operand A.
REQ-007 rN_b  input  32  requester N signed operand B.
REQ-008 rN_sel  input  3  requester N ALU op code.
REQ-009 rsp_valid  output  1  registered result available.
REQ-010 rsp_ready  input  1  consumer takes result.
REQ-011 rsp_id  output  1  index of requester that owns the result.
REQ-012 rsp_data  output  32  ALU result.
REQ-013 rsp_zero  output  1  rsp_data == 0.
REQ-014 rsp_err  output  1  op code was illegal.
REQ-015 gnt_cnt0, gnt_cnt1  output  CNT_W each  per-requester grant counts (present only with ALU_ARB_STATS_EN).

Function
REQ-016 The block SHALL share one combinational ALU between two requesters, one operation accepted per cycle at most.
REQ-017 Op codes SHALL be: 000 AND, 001 OR, 010 ADD (wrap mod 2^32), 100 A AND NOT B, 101 A OR NOT B, 110 SUB (wrap), 111 signed SLT (result 1 or 0).
REQ-018 Op code 011 SHALL be accepted normally, producing rsp_data=0, rsp_zero=1, rsp_err=1; never X.
REQ-019 States: EMPTY (no result held) and FULL (result held, rsp_valid=1).
REQ-020 Grant SHALL be possible when state is EMPTY, or FULL with rsp_ready=1 (same-cycle drain and refill).
REQ-021 Arbitration SHALL be round-robin: a last-granted pointer (reset 1, so requester 0 wins first) gives priority to the other requester when both valid.
REQ-022 A lone valid requester SHALL be granted regardless of pointer; pointer updates only on a grant.
REQ-023 rN_ready SHALL be combinational, asserted only for the granted requester, and only with rN_valid=1.
REQ-024 Latency: operation accepted in cycle T SHALL appear on rsp_* in cycle T+1; throughput one op/cycle when rsp_ready held high.
REQ-025 While FULL and rsp_ready=0, rsp_* SHALL remain stable and both rN_ready SHALL be 0.
REQ-026 FULL with rsp_ready=1 and no valid requester SHALL go to EMPTY, rsp_valid=0 next cycle.
REQ-027 Requester inputs SHALL be sampled only on their accepting cycle; later changes do not affect held results.

Reset
REQ-028 On rst_n low, state SHALL become EMPTY immediately: rsp_valid=0, rsp_id=0, rsp_data=0, rsp_zero=0, rsp_err=0, pointer=1, counters=0, rN_ready=0.
REQ-029 Reset mid-operation SHALL discard any held result without a response; first post-reset grant follows REQ-021.

Configuration
REQ-030 Macro ALU_ARB_STATS_EN defined: gnt_cnt0/gnt_cnt1 SHALL increment on each grant to that requester, saturating at 2^CNT_W-1.
REQ-031 Macro undefined: counters and their ports SHALL be absent; all other behaviour identical.

Structure
REQ-032 A shared package alu_pkg SHALL hold the 3-bit op code constants, the illegal op code, and the 32-bit data width constant.
REQ-033 The ALU SHALL be a separate sub-module alu_core (combinational, a, b, sel -> result, zero, err) instantiated once.
REQ-034 Arbitration pointer, FULL/EMPTY state and response register SHALL live in alu_arbiter.

Verification
REQ-035 r0 only, a=5, b=7, sel=010, rsp_ready=1 -> next cycle rsp_valid=1, rsp_id=0, rsp_data=12, rsp_zero=0.
REQ-036 Both valid every cycle, rsp_ready=1 -> grants alternate 0,1,0,1; rsp_id follows one cycle later.
REQ-037 r1 a=-1, b=0, sel=111, rsp_ready=0 for 3 cycles -> rsp_data=1 held stable, r0_ready=r1_ready=0, then drains on rsp_ready=1.
REQ-038 sel=011 -> rsp_data=0, rsp_zero=1, rsp_err=1; a=0x7FFFFFFF, b=1, sel=010 -> rsp_data=0x80000000.
REQ-039 rst_n pulsed low while FULL -> rsp_valid=0 asynchronously; next both-valid grant goes to requester 0.
REQ-040 With ALU_ARB_STATS_EN and CNT_W=2, five r0 grants -> gnt_cnt0=3 saturated, gnt_cnt1=0.
